// File: rtl/imem_loader.sv
// Boot loader: assembles a framed little-endian byte stream into 32-bit words,
// writes them to instruction memory and holds the core in reset until the image checksum matches.
module imem_loader #(
   parameter int          DEPTH_WORDS = 4096,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_data_i,
   output logic        byte_ready_o,
   output logic        wr_en_o,
   output logic [31:0] wr_addr_o,
   output logic [31:0] wr_data_o,
   output logic [12:0] words_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic        cpu_rst_o
);

   typedef enum logic [2:0] {
      S_HDR0,
      S_HDR1,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [16:0] DEPTH_LIM = 17'(DEPTH_WORDS);

   state_t      state_q, state_d;
   logic [7:0]  count_lo_q;
   logic [15:0] count_q;
   logic [15:0] count_hdr;
   logic [1:0]  byte_idx_q;
   logic [23:0] asm_q;
   logic [7:0]  csum_q;
   logic [12:0] words_q;
   logic        wr_en_q;
   logic [31:0] wr_addr_q;
   logic [31:0] wr_data_q;
   logic        xfer;
   logic        word_done;
   logic        last_word;
   logic        rearm;

   assign byte_ready_o = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                         (state_q == S_DATA) || (state_q == S_CSUM);
   assign xfer         = byte_valid_i && byte_ready_o;
   assign count_hdr    = {byte_data_i, count_lo_q};
   assign word_done    = xfer && (state_q == S_DATA) && (byte_idx_q == 2'd3);
   assign last_word    = word_done && (({3'b000, words_q} + 16'd1) == count_q);
   assign rearm        = start_i && ((state_q == S_DONE) || (state_q == S_ERR));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_HDR0;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_HDR0: if (xfer) state_d = S_HDR1;
         S_HDR1: begin
            if (xfer) begin
               if ({1'b0, count_hdr} > DEPTH_LIM) state_d = S_ERR;
               else if (count_hdr == 16'd0)      state_d = S_CSUM;
               else                              state_d = S_DATA;
            end
         end
         S_DATA: if (last_word) state_d = S_CSUM;
         S_CSUM: begin
            if (xfer) state_d = (byte_data_i == csum_q) ? S_DONE : S_ERR;
         end
         S_DONE: if (start_i) state_d = S_HDR0;
         S_ERR:  if (start_i) state_d = S_HDR0;
         default: state_d = S_HDR0;
      endcase
   end

   // Bytes shift in from the top so the first byte of a word ends up in bits [7:0];
   // the write address points at the pending word and advances once that word has been written.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_lo_q <= 8'd0;
         count_q    <= 16'd0;
         byte_idx_q <= 2'd0;
         asm_q      <= 24'd0;
         csum_q     <= 8'd0;
         words_q    <= 13'd0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= BASE_ADDR;
         wr_data_q  <= 32'd0;
      end else begin
         wr_en_q <= word_done;
         if (wr_en_q) wr_addr_q <= wr_addr_q + 32'd4;
         if (xfer && (state_q == S_HDR0)) count_lo_q <= byte_data_i;
         if (xfer && (state_q == S_HDR1)) count_q <= count_hdr;
         if (xfer && (state_q == S_DATA)) begin
            csum_q     <= csum_q ^ byte_data_i;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
               wr_data_q <= {byte_data_i, asm_q};
               words_q   <= words_q + 13'd1;
            end else begin
               asm_q <= {byte_data_i, asm_q[23:8]};
            end
         end
         if (rearm) begin
            words_q    <= 13'd0;
            csum_q     <= 8'd0;
            byte_idx_q <= 2'd0;
            wr_addr_q  <= BASE_ADDR;
         end
      end
   end

   assign wr_en_o   = wr_en_q;
   assign wr_addr_o = wr_addr_q;
   assign wr_data_o = wr_data_q;
   assign words_o   = words_q;
   assign busy_o    = (state_q == S_HDR1) || (state_q == S_DATA) || (state_q == S_CSUM);
   assign done_o    = (state_q == S_DONE);
   assign err_o     = (state_q == S_ERR);
   assign cpu_rst_o = (state_q != S_DONE);

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream boot loader that fills the instruction memory before the core runs.
- Receives a framed byte stream (from a UART RX or a debug bridge) and assembles little-endian 32-bit words.
- Drives the instruction memory's write port with word-aligned byte addresses; the memory indexes words by addr>>2.
- Holds the CPU in reset until a complete, checksum-valid image has been written.

Parameters:
- DEPTH_WORDS, 4096, instruction memory capacity in words; frames with a larger count are rejected.
- BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be 4-byte aligned.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  re-arm pulse; honoured only in DONE or ERR
- byte_valid_i  in  1  stream byte valid
- byte_data_i  in  8  stream byte
- byte_ready_o  out  1  loader accepts a byte this cycle
- wr_en_o  out  1  memory write strobe, one cycle per word
- wr_addr_o  out  32  byte address of the write, word-aligned
- wr_data_o  out  32  write data word
- words_o  out  13  words written in the current frame
- busy_o  out  1  frame in progress (HDR1, DATA, CSUM)
- done_o  out  1  image loaded and checksum OK
- err_o  out  1  frame rejected
- cpu_rst_o  out  1  core reset request, high until done

Behaviour:
- Frame format, in order:
  - count: 16-bit word count N, little-endian, 2 bytes.
  - data: 4*N bytes, little-endian per word (first byte goes to bits [7:0]).
  - checksum: 1 byte, XOR of all data bytes; header bytes are not included.
- Handshake: a byte transfers on a cycle where byte_valid_i and byte_ready_o are both high. byte_ready_o is combinational: 1 in HDR0/HDR1/DATA/CSUM, 0 in DONE/ERR. There is no other backpressure.
- State machine:
  - HDR0: on transfer, capture count[7:0] -> HDR1.
  - HDR1: on transfer, capture count[15:8].
    - If N > DEPTH_WORDS -> ERR.
    - Else if N == 0 -> CSUM.
    - Else -> DATA.
  - DATA: each transfer shifts into the word assembler, XORs into the running checksum and increments a 2-bit byte index. On the 4th byte: register the word, assert wr_en_o on the next cycle, and increment words_o in that same cycle. When the Nth word completes -> CSUM.
  - CSUM: on transfer, compare the byte with the running XOR. Equal -> DONE; unequal -> ERR.
  - DONE: done_o=1, cpu_rst_o=0. start_i -> HDR0.
  - ERR: err_o=1, cpu_rst_o=1. start_i -> HDR0.
- Write port:
  - wr_en_o is high for exactly one cycle per word, 1 cycle after the 4th byte is accepted.
  - wr_addr_o/wr_data_o are valid while wr_en_o is high.
  - wr_addr_o = BASE_ADDR + 4*(word index). It advances by 4 after each write and wraps modulo 2^32 (unreachable when N is within range).
- Back-to-back bytes every cycle are supported; a write and a new byte acceptance may occur in the same cycle.
- Re-arm via start_i:
  - Clears words_o, checksum, byte index, done_o and err_o.
  - Returns wr_addr_o to BASE_ADDR.
  - Sets cpu_rst_o=1.
  - start_i in any other state is ignored.
- Reset values (asynchronous, any state including mid-frame):
  - state HDR0, so byte_ready_o=1.
  - wr_en_o=0, wr_addr_o=BASE_ADDR, wr_data_o=0, words_o=0.
  - busy_o=0, done_o=0, err_o=0, cpu_rst_o=1.
  - A partially assembled word is discarded and never written.
- busy_o is 0 in HDR0 (so idle-after-reset reads not busy) and 1 in HDR1/DATA/CSUM.

Test Plan:
- Stream 02 00 13 00 00 00 93 00 10 00 90 -> writes (0x0, 0x00000013) and (0x4, 0x00100093), one wr_en_o pulse each; words_o=2, done_o=1, cpu_rst_o=0, byte_ready_o=0.
- Same frame with checksum byte 0x91 -> both writes still occur; err_o=1, done_o=0, cpu_rst_o=1. Then start_i plus the correct frame -> done_o=1.
- Header 01 10 (N=4097, DEPTH_WORDS=4096) -> ERR immediately after the 2nd byte; no wr_en_o ever asserted.
- Header 00 00 followed by checksum 00 -> DONE with words_o=0 and no writes. Same header followed by 0x5A -> ERR.
- Assert rst_i after 6 data bytes of a 2-word frame -> outputs return to reset values; the 2nd word is never written; a fresh full frame loads correctly from BASE_ADDR.
- Toggle byte_valid_i randomly (50%) across a 16-word frame -> same addresses and data as the back-to-back case; start_i pulsed mid-frame has no effect.
